prog_clk_div: RTL

Runtime-programmable clock divider, the parametrised successor of the fixed divide-by-8 block. It produces a divided clock with a programmable ratio and a selectable duty mode, plus a period-start tick. New ratio/duty settings are accepted at any time but take effect only at a period boundary, so the output never glitches. It drives the slow-clock and strobe consumers in the peripheral section and is gated by an enable, as C1 gated the original divider.

---
 rtl/prog_clk_div.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/prog_clk_div.sv
// Runtime-programmable clock divider.
// Produces a registered divided clock with programmable ratio and duty mode,
// plus a one-cycle tick on the first cycle of each output period. New settings
// loaded while running are held pending and only take effect at a period
// boundary, so the output never glitches.
module prog_clk_div #(
    parameter int CNT_W     = 8,
    parameter int RESET_DIV = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             cfg_mode,
    output logic             clk_out,
    output logic             tick,
    output logic             cfg_pending,
    output logic             running
);

    // Reset configuration, already clamped: ratio RESET_DIV, half duty.
    localparam int               RESET_N_INT = (RESET_DIV < 2) ? 2 : RESET_DIV;
    localparam logic [CNT_W-1:0] RESET_NEFF  = CNT_W'(RESET_N_INT);
    localparam logic [CNT_W-1:0] RESET_HEFF  = CNT_W'(RESET_N_INT / 2);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             clk_out_reg, clk_out_next;
    logic             tick_reg, tick_next;

    // Active configuration holds the clamped (effective) values.
    logic [CNT_W-1:0] act_div_reg, act_div_next;
    logic [CNT_W-1:0] act_high_reg, act_high_next;

    // Pending configuration holds the raw values as loaded.
    logic             pend_valid_reg, pend_valid_next;
    logic [CNT_W-1:0] pend_div_reg, pend_div_next;
    logic [CNT_W-1:0] pend_high_reg, pend_high_next;
    logic             pend_mode_reg, pend_mode_next;

    // Clamp sources: index 0 is the live cfg inputs (direct load while idle),
    // index 1 is the pending registers (applied at a boundary).
    logic [CNT_W-1:0] src_div  [2];
    logic [CNT_W-1:0] src_high [2];
    logic             src_mode [2];
    logic [CNT_W-1:0] eff_div  [2];
    logic [CNT_W-1:0] eff_high [2];

    assign src_div[0]  = cfg_div;
    assign src_high[0] = cfg_high;
    assign src_mode[0] = cfg_mode;
    assign src_div[1]  = pend_div_reg;
    assign src_high[1] = pend_high_reg;
    assign src_mode[1] = pend_mode_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_clamp
            // Ratio below 2 is clamped to 2; high time is kept within 1..Neff-1.
            always_comb begin
                eff_div[gi]  = (src_div[gi] < CNT_W'(2)) ? CNT_W'(2) : src_div[gi];
                eff_high[gi] = eff_div[gi] >> 1;
                if (src_mode[gi]) begin
                    if (src_high[gi] == '0) begin
                        eff_high[gi] = CNT_W'(1);
                    end else if (src_high[gi] >= eff_div[gi]) begin
                        eff_high[gi] = eff_div[gi] - CNT_W'(1);
                    end else begin
                        eff_high[gi] = src_high[gi];
                    end
                end
            end
        end
    endgenerate

    logic             boundary;
    logic [CNT_W-1:0] cnt_inc;

    assign boundary = (cnt_reg == act_div_reg - CNT_W'(1));
    assign cnt_inc  = cnt_reg + CNT_W'(1);

    // Next-state logic: idle/run control, counter, outputs and config handling.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        clk_out_next    = clk_out_reg;
        tick_next       = 1'b0;
        act_div_next    = act_div_reg;
        act_high_next   = act_high_reg;
        pend_valid_next = pend_valid_reg;
        pend_div_next   = pend_div_reg;
        pend_high_next  = pend_high_reg;
        pend_mode_next  = pend_mode_reg;

        case (state_reg)
            ST_IDLE: begin
                cnt_next     = '0;
                clk_out_next = 1'b0;
                // Idle load goes straight to active so a start on the same
                // edge already uses it.
                if (cfg_load) begin
                    act_div_next  = eff_div[0];
                    act_high_next = eff_high[0];
                end
                if (en) begin
                    state_next   = ST_RUN;
                    cnt_next     = '0;
                    clk_out_next = 1'b1;
                    tick_next    = 1'b1;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    state_next   = ST_IDLE;
                    cnt_next     = '0;
                    clk_out_next = 1'b0;
                end else if (boundary) begin
                    cnt_next     = '0;
                    clk_out_next = 1'b1;
                    tick_next    = 1'b1;
                    if (pend_valid_reg) begin
                        act_div_next    = eff_div[1];
                        act_high_next   = eff_high[1];
                        pend_valid_next = 1'b0;
                    end
                end else begin
                    cnt_next     = cnt_inc;
                    clk_out_next = (cnt_inc < act_high_reg);
                end
                // A load while running always lands in pending; on a boundary
                // edge this happens after the old pending was consumed.
                if (cfg_load) begin
                    pend_valid_next = 1'b1;
                    pend_div_next   = cfg_div;
                    pend_high_next  = cfg_high;
                    pend_mode_next  = cfg_mode;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            clk_out_reg    <= 1'b0;
            tick_reg       <= 1'b0;
            act_div_reg    <= RESET_NEFF;
            act_high_reg   <= RESET_HEFF;
            pend_valid_reg <= 1'b0;
            pend_div_reg   <= '0;
            pend_high_reg  <= '0;
            pend_mode_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            clk_out_reg    <= clk_out_next;
            tick_reg       <= tick_next;
            act_div_reg    <= act_div_next;
            act_high_reg   <= act_high_next;
            pend_valid_reg <= pend_valid_next;
            pend_div_reg   <= pend_div_next;
            pend_high_reg  <= pend_high_next;
            pend_mode_reg  <= pend_mode_next;
        end
    end

    assign clk_out     = clk_out_reg;
    assign tick        = tick_reg;
    assign cfg_pending = pend_valid_reg;
    assign running     = (state_reg == ST_RUN);

endmodule
